// File: rtl/encoder_8to3_seq.sv
// Serializes the set bits of an 8-bit request vector into 3-bit indices, lowest first, flagging the last.
// First index is registered 1 cycle after acceptance; out_ready low holds the beat; en gates new vectors only.
module encoder_8to3_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       in_ready,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic       out_last,
  input  logic       out_ready,
  output logic       zero_drop
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt;
  logic [7:0] cleared;
  logic       valid_nxt;
  logic [2:0] idx_nxt;
  logic       last_nxt;
  logic       drop_nxt;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  assign in_ready = (state == IDLE) && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 8'd0;
      out_valid <= 1'b0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
      zero_drop <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      out_valid <= valid_nxt;
      out_idx   <= idx_nxt;
      out_last  <= last_nxt;
      zero_drop <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    valid_nxt   = out_valid;
    idx_nxt     = out_idx;
    last_nxt    = out_last;
    drop_nxt    = 1'b0;
    cleared     = pending & ~(8'd1 << out_idx);
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in != 8'd0) begin
            pending_nxt = in;
            state_nxt   = SCAN;
            valid_nxt   = 1'b1;
            idx_nxt     = lowest_set(in);
            last_nxt    = single_bit(in);
          end else begin
            drop_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        // out_valid is always high in SCAN, so out_ready alone completes a beat
        if (out_ready) begin
          pending_nxt = cleared;
          if (out_last) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            idx_nxt   = 3'd0;
            last_nxt  = 1'b0;
          end else begin
            idx_nxt  = lowest_set(cleared);
            last_nxt = single_bit(cleared);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed bench for encoder_8to3_seq: one-hot sweep, multi-hot, backpressure, enable/zero, reset, round trip.
module tb_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] in;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_ready;
  logic       zero_drop;

  int vectors = 0;
  int miscompares = 0;

  encoder_8to3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in        (in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .zero_drop (zero_drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    in       = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] decoder_3to8(input logic [2:0] idx, input logic dec_en);
    return dec_en ? (8'd1 << idx) : 8'd0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] ms_idx [4];
    logic [3:0] pat;
    logic [2:0] held_idx;
    logic       held_last;
    logic       held;
    logic [7:0] acc;
    int         beats;
    int         cyc;
    logic       seen_last;

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in = 8'd0; out_ready = 1'b1;
    tick();
    check_eq("rst_in_ready_en0", in_ready, 0);
    en = 1'b1;
    #1;
    check_eq("rst_in_ready_en1", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_zero_drop", zero_drop, 0);
    rst = 1'b0;
    tick();

    // One-hot sweep
    for (int i = 0; i < 8; i++) begin
      check_eq("sweep_ready_before", in_ready, 1);
      send(8'd1 << i);
      check_eq("sweep_ready_low", in_ready, 0);
      check_eq("sweep_valid", out_valid, 1);
      check_eq("sweep_idx", out_idx, i);
      check_eq("sweep_last", out_last, 1);
      tick();
      check_eq("sweep_valid_after", out_valid, 0);
      check_eq("sweep_ready_after", in_ready, 1);
    end

    // Multi-hot 1010_0110 -> 1,2,5,7
    ms_idx[0] = 3'd1; ms_idx[1] = 3'd2; ms_idx[2] = 3'd5; ms_idx[3] = 3'd7;
    send(8'b1010_0110);
    for (int i = 0; i < 4; i++) begin
      check_eq("multi_valid", out_valid, 1);
      check_eq("multi_idx", out_idx, ms_idx[i]);
      check_eq("multi_last", out_last, (i == 3) ? 1 : 0);
      check_eq("multi_ready_low", in_ready, 0);
      tick();
    end
    check_eq("multi_valid_after", out_valid, 0);
    check_eq("multi_ready_after", in_ready, 1);

    // Backpressure on 0xFF with out_ready pattern 1,0,0,1
    pat = 4'b1001;
    send(8'hFF);
    beats = 0;
    cyc = 0;
    held = 1'b0;
    held_idx = 3'd0;
    held_last = 1'b0;
    while (beats < 8 && cyc < 64) begin
      if (held) begin
        check_eq("bp_idx_stable", out_idx, held_idx);
        check_eq("bp_last_stable", out_last, held_last);
        check_eq("bp_valid_stable", out_valid, 1);
      end
      out_ready = pat[cyc % 4];
      if (out_valid && out_ready) begin
        check_eq("bp_idx", out_idx, beats);
        check_eq("bp_last", out_last, (beats == 7) ? 1 : 0);
        beats++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_idx = out_idx;
        held_last = out_last;
      end
      tick();
      cyc++;
    end
    check_eq("bp_beat_count", beats, 8);
    check_eq("bp_valid_after", out_valid, 0);
    out_ready = 1'b1;

    // Enable gating and zero vectors
    en = 1'b0; in = 8'h10; in_valid = 1'b1;
    #1;
    check_eq("en0_in_ready", in_ready, 0);
    tick();
    check_eq("en0_no_beat", out_valid, 0);
    check_eq("en0_no_drop", zero_drop, 0);
    en = 1'b1; in = 8'h00;
    #1;
    check_eq("zero_in_ready", in_ready, 1);
    tick();
    check_eq("zero_drop_1", zero_drop, 1);
    check_eq("zero_no_valid", out_valid, 0);
    tick();
    check_eq("zero_drop_2", zero_drop, 1);
    in_valid = 1'b0;
    tick();
    check_eq("zero_drop_end", zero_drop, 0);
    send(8'h10);
    check_eq("en1_valid", out_valid, 1);
    check_eq("en1_idx", out_idx, 4);
    check_eq("en1_last", out_last, 1);
    check_eq("en1_no_drop", zero_drop, 0);
    tick();
    check_eq("en1_valid_after", out_valid, 0);

    // Reset mid-operation
    send(8'hF0);
    check_eq("rmid_idx4", out_idx, 4);
    check_eq("rmid_last4", out_last, 0);
    tick();
    check_eq("rmid_idx5_shown", out_idx, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rmid_valid", out_valid, 0);
    check_eq("rmid_idx", out_idx, 0);
    check_eq("rmid_in_ready", in_ready, 1);
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) beats++;
    end
    check_eq("rmid_no_beats", beats, 0);

    // Round trip over all nonzero vectors
    for (int v = 1; v < 256; v++) begin
      check_eq("rt_ready", in_ready, 1);
      send(8'(v));
      acc = 8'd0;
      beats = 0;
      seen_last = 1'b0;
      for (int c = 0; c < 12 && !seen_last; c++) begin
        if (out_valid) begin
          acc |= decoder_3to8(out_idx, 1'b1);
          beats++;
          seen_last = out_last;
        end
        tick();
      end
      check_eq("rt_or", acc, v);
      check_eq("rt_count", beats, $countones(8'(v)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
